blink_req_sched: RTL and testbench

- Sequencer and two-port arbiter in front of one Blink-128 tweakable block cipher core (clocked, 16 rounds, 128-bit block, 256-bit tweak, 1024-bit round-key bundle).
- Accepts encrypt/decrypt requests from two requesters and grants them round-robin.
- Holds the core inputs stable while a job runs, restarts the core per job, counts the core latency, then captures the result.
- Returns each result with the requester ID. Also owns the key register, which is written only while the core is idle.

---
 rtl/blink_pkg.sv | 23 ++
 rtl/blink_rr_arb2.sv | 12 +
 rtl/blink_req_sched.sv | 130 +++++++++++++
 tb/tb_blink_req_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared constants, FSM state encoding and job record for the Blink-128 request scheduler.
package blink_pkg;

    localparam int BLINK_N      = 128;
    localparam int BLINK_TW     = 256;
    localparam int BLINK_KW     = 1024;
    localparam int BLINK_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } blink_state_e;

    typedef struct packed {
        logic                id;
        logic                enc;
        logic [BLINK_N-1:0]  p;
        logic [BLINK_TW-1:0] t;
    } blink_job_t;

endpackage

// File: rtl/blink_rr_arb2.sv
// Two-input round-robin grant: the prio requester wins a tie, otherwise any lone valid wins.
module blink_rr_arb2 (
    input  logic       prio_i,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt_o[gi] = valid_i[gi] & ((prio_i == 1'(gi)) | ~valid_i[1-gi]);
    end

endmodule

// File: rtl/blink_req_sched.sv
// Two-port sequencer/arbiter feeding one Blink-128 core: grants jobs round-robin,
// restarts the core per job, waits out its latency and hands the result back with the requester ID.
module blink_req_sched
    import blink_pkg::*;
#(
    parameter int N        = BLINK_N,
    parameter int TW       = BLINK_TW,
    parameter int KW       = BLINK_KW,
    parameter int CORE_LAT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_enc,
    input  logic [N-1:0]  req0_p,
    input  logic [TW-1:0] req0_t,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_enc,
    input  logic [N-1:0]  req1_p,
    input  logic [TW-1:0] req1_t,
    input  logic          key_we,
    input  logic [KW-1:0] key_in,
    output logic          key_ack,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [N-1:0]  rsp_c,
    output logic          core_rst,
    output logic          core_enc,
    output logic [N-1:0]  core_p,
    output logic [TW-1:0] core_t,
    output logic [KW-1:0] core_k,
    input  logic [N-1:0]  core_c
);

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    blink_state_e  state_q;
    logic          prio_q;
    logic [KW-1:0] key_q;
    blink_job_t    job_q;
    logic [CW-1:0] cnt_q;
    logic          core_rst_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [N-1:0]  rsp_c_q;

    logic [1:0] valid_vec;
    logic [1:0] gnt;
    logic       idle;

    assign valid_vec = {req1_valid, req0_valid};

    blink_rr_arb2 u_arb (
        .prio_i  (prio_q),
        .valid_i (valid_vec),
        .gnt_o   (gnt)
    );

    // A pending key write blocks any grant in the same IDLE cycle.
    assign idle       = (state_q == IDLE);
    assign key_ack    = idle & key_we;
    assign req0_ready = idle & ~key_we & gnt[0];
    assign req1_ready = idle & ~key_we & gnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            key_q       <= '0;
            job_q       <= '0;
            cnt_q       <= '0;
            core_rst_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_c_q     <= '0;
        end else begin
            core_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_we) begin
                        key_q <= key_in;
                    end else if (gnt[0]) begin
                        job_q      <= '{id: 1'b0, enc: req0_enc, p: req0_p, t: req0_t};
                        core_rst_q <= 1'b1;
                        state_q    <= LOAD;
                    end else if (gnt[1]) begin
                        job_q      <= '{id: 1'b1, enc: req1_enc, p: req1_p, t: req1_t};
                        core_rst_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_q   <= CW'(CORE_LAT - 1);
                    state_q <= RUN;
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        rsp_c_q     <= core_c;
                        rsp_id_q    <= job_q.id;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        prio_q      <= ~job_q.id;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_rst  = core_rst_q;
    assign core_enc  = job_q.enc;
    assign core_p    = job_q.p;
    assign core_t    = job_q.t;
    assign core_k    = key_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_blink_req_sched.sv
// Scoreboard bench for blink_req_sched with a behavioural stand-in for the Blink-128 core.
module tb_blink_req_sched;

    localparam int N        = 128;
    localparam int TW       = 256;
    localparam int KW       = 1024;
    localparam int CORE_LAT = 16;

    localparam logic [KW-1:0] K1 = {128'hA1A1_0000_1111_2222_3333_4444_5555_0001, 768'h0,
                                    128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978};
    localparam logic [KW-1:0] K2 = {128'h0BAD_F00D_0000_0000_0000_0000_0000_0002, 768'h0,
                                    128'hFEDC_BA98_7654_3210_1234_5678_9ABC_DEF0};
    localparam logic [KW-1:0] K3 = {128'h3333_3333_0000_0000_0000_0000_0000_0003, 768'h0,
                                    128'h5555_AAAA_5555_AAAA_0000_FFFF_0000_FFFF};

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_enc;
    logic [N-1:0]  req0_p;
    logic [TW-1:0] req0_t;
    logic          req1_valid, req1_ready, req1_enc;
    logic [N-1:0]  req1_p;
    logic [TW-1:0] req1_t;
    logic          key_we, key_ack;
    logic [KW-1:0] key_in;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0]  rsp_c;
    logic          core_rst, core_enc;
    logic [N-1:0]  core_p;
    logic [TW-1:0] core_t;
    logic [KW-1:0] core_k;
    logic [N-1:0]  core_c;

    always #5 clk = ~clk;

    blink_req_sched #(.N(N), .TW(TW), .KW(KW), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_enc(req0_enc),
        .req0_p(req0_p), .req0_t(req0_t),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_enc(req1_enc),
        .req1_p(req1_p), .req1_t(req1_t),
        .key_we(key_we), .key_in(key_in), .key_ack(key_ack),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .core_rst(core_rst), .core_enc(core_enc), .core_p(core_p), .core_t(core_t),
        .core_k(core_k), .core_c(core_c)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         id;
        logic [N-1:0] c;
    } exp_t;

    exp_t          sb[$];
    logic [KW-1:0] key_model = '0;

    // Stand-in cipher: output is only correct exactly CORE_LAT-1 cycles into the run.
    function automatic logic [N-1:0] golden(input logic enc, input logic [N-1:0] p,
                                            input logic [TW-1:0] t, input logic [KW-1:0] k);
        logic [N-1:0] x;
        x = {p[N-2:0], p[N-1]} ^ t[N-1:0] ^ t[TW-1:N] ^ k[N-1:0] ^ k[KW-1:KW-N];
        return enc ? x : (~x ^ {{(N-1){1'b0}}, 1'b1});
    endfunction

    int unsigned ccnt = 0;
    always @(posedge clk) begin
        if (core_rst) ccnt <= 0;
        else if (ccnt < 1000) ccnt <= ccnt + 1;
    end
    assign core_c = (ccnt == CORE_LAT - 1) ? golden(core_enc, core_p, core_t, core_k)
                                           : {4{32'hDEAD_BEEF}};

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic enc, input logic [N-1:0] p, input logic [TW-1:0] t);
        sb.push_back({id, golden(enc, p, t, key_model)});
    endtask

    // Monitor: every response handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d c %h, expected no response", rsp_id, rsp_c);
            end else begin
                e = sb.pop_front();
                check1("rsp_id", rsp_id, e.id);
                check128("rsp_c", rsp_c, e.c);
                $display("rsp id=%0d c=%h", rsp_id, rsp_c);
            end
        end
    end

    // Presents a job and returns 1ns after the accepting edge (cycle 1 of the job).
    task automatic send(input logic id, input logic enc, input logic [N-1:0] p, input logic [TW-1:0] t);
        logic got;
        got = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_enc = enc; req1_p = p; req1_t = t; end
        else    begin req0_valid = 1'b1; req0_enc = enc; req0_p = p; req0_t = t; end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
        end
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        check1(id ? "accept_req1" : "accept_req0", got, 1'b1);
        $display("req%0d accepted p=%h", id, p);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check1("drain", sb.size() == 0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_c;
        logic         seen;
        rst = 1'b1;
        req0_valid = 0; req0_enc = 0; req0_p = '0; req0_t = '0;
        req1_valid = 0; req1_enc = 0; req1_p = '0; req1_t = '0;
        key_we = 0; key_in = '0; rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check1("rst_core_rst", core_rst, 1'b1);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_rsp_id", rsp_id, 1'b0);
        check128("rst_rsp_c", rsp_c, '0);
        check128("rst_core_p", core_p, '0);
        check128("rst_core_k", core_k[127:0], '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Key load, then single encrypt job on requester 0
        key_we = 1'b1; key_in = K1;
        @(negedge clk);
        check1("key_ack_idle", key_ack, 1'b1);
        @(posedge clk); #1;
        key_we = 1'b0; key_model = K1;
        @(negedge clk);
        check128("key_loaded", core_k[127:0], K1[127:0]);
        @(posedge clk); #1;
        push(1'b0, 1'b1, 128'h1, '0);
        send(1'b0, 1'b1, 128'h1, '0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            check1("core_rst_cycle", core_rst, c == 1);
            check1("rsp_valid_cycle", rsp_valid, c == 18);
            @(posedge clk); #1;
        end
        wait_drain();

        // Back-pressure: requester 1 job, response held for 10 cycles
        rsp_ready = 1'b0;
        exp_c = golden(1'b0, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF, {2{128'h77}}, key_model);
        push(1'b1, 1'b0, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF, {2{128'h77}});
        send(1'b1, 1'b0, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF, {2{128'h77}});
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
            if (!seen) begin @(posedge clk); #1; end
        end
        check1("bp_rsp_seen", seen, 1'b1);
        for (int s = 1; s <= 10; s++) begin
            if (s > 1) @(negedge clk);
            check1("bp_rsp_valid", rsp_valid, 1'b1);
            check1("bp_rsp_id", rsp_id, 1'b1);
            check128("bp_rsp_c", rsp_c, exp_c);
            check1("bp_req0_ready", req0_ready, 1'b0);
            check1("bp_req1_ready", req1_ready, 1'b0);
            @(posedge clk); #1;
            if (s == 1) begin req0_valid = 1'b1; req0_p = 128'h99; end
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check1("bp_back_idle", rsp_valid, 1'b0);
        @(posedge clk); #1;
        wait_drain();

        // Contention: both requesters keep valid high, expect 0,1,0,1
        push(1'b0, 1'b1, 128'hA0, {2{128'h10}});
        push(1'b1, 1'b1, 128'hB1, {2{128'h20}});
        push(1'b0, 1'b0, 128'hA2, {2{128'h30}});
        push(1'b1, 1'b0, 128'hB3, {2{128'h40}});
        fork
            begin
                send(1'b0, 1'b1, 128'hA0, {2{128'h10}});
                send(1'b0, 1'b0, 128'hA2, {2{128'h30}});
            end
            begin
                send(1'b1, 1'b1, 128'hB1, {2{128'h20}});
                send(1'b1, 1'b0, 128'hB3, {2{128'h40}});
            end
        join
        wait_drain();

        // Key write collides with a request in IDLE
        key_we = 1'b1; key_in = K2;
        req1_valid = 1'b1; req1_enc = 1'b1; req1_p = 128'h4444; req1_t = {2{128'h5}};
        @(negedge clk);
        check1("kc_key_ack", key_ack, 1'b1);
        check1("kc_req1_ready", req1_ready, 1'b0);
        @(posedge clk); #1;
        key_we = 1'b0; key_model = K2;
        push(1'b1, 1'b1, 128'h4444, {2{128'h5}});
        @(negedge clk);
        check1("kc_req1_granted", req1_ready, 1'b1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        check128("kc_core_k_hi", core_k[KW-1:KW-128], K2[KW-1:KW-128]);
        @(posedge clk); #1;
        wait_drain();

        // Key write raised mid-run must wait for IDLE
        push(1'b0, 1'b1, 128'h5151, {2{128'h6}});
        send(1'b0, 1'b1, 128'h5151, {2{128'h6}});
        repeat (5) begin @(posedge clk); #1; end
        key_we = 1'b1; key_in = K3;
        for (int c = 6; c <= 18; c++) begin
            @(negedge clk);
            check1("kr_key_ack", key_ack, 1'b0);
            check128("kr_core_k_lo", core_k[127:0], K2[127:0]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check1("kr_key_ack_idle", key_ack, 1'b1);
        @(posedge clk); #1;
        key_we = 1'b0; key_model = K3;
        @(negedge clk);
        check128("kr_core_k_new", core_k[127:0], K3[127:0]);
        @(posedge clk); #1;
        wait_drain();

        // Reset when the run counter reaches 5: job discarded
        send(1'b1, 1'b0, 128'h6666, {2{128'h7}});
        repeat (11) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check1("mr_rsp_valid", rsp_valid, 1'b0);
        check1("mr_core_rst", core_rst, 1'b1);
        check128("mr_core_p", core_p, '0);
        @(posedge clk); #1;
        rst = 1'b0; key_model = '0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check1("mr_no_rsp", seen, 1'b0);
        push(1'b0, 1'b0, 128'h7777, {2{128'h8}});
        send(1'b0, 1'b0, 128'h7777, {2{128'h8}});
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
